// File: rtl/mips_pkg.sv
// ---------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the MIPS pipeline front end.
//   INSTR_W          : instruction width in bits
//   NOP_INSTR        : encoding presented to decode when nothing is queued
//   DEFAULT_RESET_PC : boot address of the program ROM
//   fetch_entry_t    : one fetch-queue slot, {PC+4, instruction}
//   alignWord()      : clears the byte-offset bits of an address
// ---------------------------------------------------------------------------
package mips_pkg;

    localparam int          INSTR_W          = 32;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0040_0000;

    typedef struct packed {
        logic [31:0]        pcPlus4;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    localparam int ENTRY_W = $bits(fetch_entry_t);

    // Instructions are word aligned; a redirect target with low bits set
    // is rounded down to the containing word.
    function automatic logic [31:0] alignWord(input logic [31:0] addr);
        return addr & ~32'd3;
    endfunction

endpackage

// File: rtl/fetch_queue_stage_if.sv
// ---------------------------------------------------------------------------
// fetch_queue_stage_if
// Bundles the fetch stage's ROM port, redirect input, decode handshake and
// debug outputs.
//   master : the fetch stage (drives ROM address, decode-side outputs)
//   slave  : the environment (ROM, MEM-stage redirect, decode)
// ---------------------------------------------------------------------------
interface fetch_queue_stage_if
    import mips_pkg::*;
#(
    parameter int DEPTH = 4
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [31:0]        imemAddr;
    logic [INSTR_W-1:0] imemInstr;
    logic               redirect;
    logic [31:0]        redirectPc;
    logic               idReady;
    logic               idValid;
    logic [31:0]        idPcPlus4;
    logic [INSTR_W-1:0] idInstruction;
    logic [31:0]        fetchPc;
    logic [CNT_W-1:0]   occupancy;

    modport master (
        output imemAddr,
        input  imemInstr,
        input  redirect,
        input  redirectPc,
        input  idReady,
        output idValid,
        output idPcPlus4,
        output idInstruction,
        output fetchPc,
        output occupancy
    );

    modport slave (
        input  imemAddr,
        output imemInstr,
        output redirect,
        output redirectPc,
        output idReady,
        input  idValid,
        input  idPcPlus4,
        input  idInstruction,
        input  fetchPc,
        input  occupancy
    );

endinterface

// File: rtl/fetch_queue_stage_fifo.sv
// ---------------------------------------------------------------------------
// fetch_fifo
// Circular buffer holding fetched entries, with a combinational head read.
//   clk, rstN : clock (rising edge), asynchronous active-low reset
//   push      : write wrData at the tail
//   pop       : drop the head entry
//   flush     : discard everything (overrides push/pop)
//   rdData    : head entry (undefined content when empty)
//   empty/full: status flags
//   count     : number of entries held, 0..DEPTH
// DEPTH must be a power of two so pointers wrap naturally.
// ---------------------------------------------------------------------------
module fetch_fifo #(
    parameter  int DEPTH = 4,
    parameter  int WIDTH = 64,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wrData,
    output logic [WIDTH-1:0] rdData,
    output logic             empty,
    output logic             full,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] memReg [DEPTH];

    logic [PTR_W-1:0] wrPtrReg, wrPtrNext;
    logic [PTR_W-1:0] rdPtrReg, rdPtrNext;
    logic [CNT_W-1:0] countReg, countNext;

    always_comb begin
        wrPtrNext = wrPtrReg;
        rdPtrNext = rdPtrReg;
        countNext = countReg;
        if (flush) begin
            wrPtrNext = '0;
            rdPtrNext = '0;
            countNext = '0;
        end else begin
            if (push) wrPtrNext = wrPtrReg + PTR_W'(1);
            if (pop)  rdPtrNext = rdPtrReg + PTR_W'(1);
            // Simultaneous push and pop leaves the count unchanged.
            if (push && !pop)      countNext = countReg + CNT_W'(1);
            else if (pop && !push) countNext = countReg - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            wrPtrReg <= '0;
            rdPtrReg <= '0;
            countReg <= '0;
        end else begin
            wrPtrReg <= wrPtrNext;
            rdPtrReg <= rdPtrNext;
            countReg <= countNext;
        end
    end

    // Storage needs no reset: nothing is read out while count is zero.
    always_ff @(posedge clk) begin
        if (push && !flush) memReg[wrPtrReg] <= wrData;
    end

    assign rdData = memReg[rdPtrReg];
    assign empty  = (countReg == '0);
    assign full   = (countReg == CNT_W'(DEPTH));
    assign count  = countReg;

endmodule

// File: rtl/fetch_queue_stage.sv
// ---------------------------------------------------------------------------
// fetch_queue_stage
// Instruction-fetch front end: owns the PC, addresses the program ROM and
// queues {PC+4, instruction} pairs for decode so decode stalls lose nothing.
// A redirect from MEM flushes the queue and reloads the PC.
//   clk  : clock, rising edge
//   rstN : asynchronous active-low reset
//   bus  : fetch_queue_stage_if.master
//            imemAddr/imemInstr      combinational ROM port
//            redirect/redirectPc     branch/jump from MEM
//            idReady/idValid/idPcPlus4/idInstruction  decode handshake
//            fetchPc, occupancy      debug visibility
// ---------------------------------------------------------------------------
module fetch_queue_stage
    import mips_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input logic                 clk,
    input logic                 rstN,
    fetch_queue_stage_if.master bus
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [31:0]      pcReg, pcNext;
    logic [31:0]      pcPlus4;
    logic             fifoPush, fifoPop;
    logic             fifoEmpty, fifoFull;
    logic [CNT_W-1:0] fifoCount;
    fetch_entry_t     wrEntry, headEntry;

    assign pcPlus4 = pcReg + 32'd4;

    // Redirect suppresses both sides of the queue; a full queue still
    // accepts a new word when decode takes the head in the same cycle.
    assign fifoPop  = ~fifoEmpty & bus.idReady & ~bus.redirect;
    assign fifoPush = ~bus.redirect & (~fifoFull | fifoPop);

    always_comb begin
        pcNext = pcReg;
        if (bus.redirect)  pcNext = alignWord(bus.redirectPc);
        else if (fifoPush) pcNext = pcPlus4;
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) pcReg <= RESET_PC;
        else       pcReg <= pcNext;
    end

    assign wrEntry = '{pcPlus4: pcPlus4, instr: bus.imemInstr};

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk    (clk),
        .rstN   (rstN),
        .push   (fifoPush),
        .pop    (fifoPop),
        .flush  (bus.redirect),
        .wrData (wrEntry),
        .rdData (headEntry),
        .empty  (fifoEmpty),
        .full   (fifoFull),
        .count  (fifoCount)
    );

    // ROM address comes straight from the PC register, so there is no
    // combinational path from redirect or idReady into the ROM.
    assign bus.imemAddr      = pcReg;
    assign bus.fetchPc       = pcReg;
    assign bus.idValid       = ~fifoEmpty;
    assign bus.idPcPlus4     = fifoEmpty ? 32'd0     : headEntry.pcPlus4;
    assign bus.idInstruction = fifoEmpty ? NOP_INSTR : headEntry.instr;
    assign bus.occupancy     = fifoCount;

endmodule

// File: tb/tb_fetch_queue_stage.sv
// ---------------------------------------------------------------------------
// tb_fetch_queue_stage
// Self-checking bench for fetch_queue_stage. A queue-based reference model
// tracks the PC and the decode-visible entries; directed scenario tasks and
// a randomized run compare the DUT against it.
// ---------------------------------------------------------------------------
module tb_fetch_queue_stage;
    import mips_pkg::*;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0040_0000;

    logic clk;
    logic rstN;

    fetch_queue_stage_if #(.DEPTH(DEPTH)) bus ();

    fetch_queue_stage #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk  (clk),
        .rstN (rstN),
        .bus  (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Program ROM: address-derived pattern, combinational.
    function automatic logic [31:0] romFn(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC001_D00D;
    endfunction

    assign bus.imemInstr = romFn(bus.imemAddr);

    // Reference model: queue of {pc+4, instr} plus the PC.
    logic [63:0] mq[$];
    logic [31:0] mPc;

    int errors = 0;
    int checks = 0;

    function automatic logic [31:0] expPc4();
        return (mq.size() != 0) ? mq[0][63:32] : 32'd0;
    endfunction

    function automatic logic [31:0] expInstr();
        return (mq.size() != 0) ? mq[0][31:0] : 32'd0;
    endfunction

    // Advance one clock, updating the model from the inputs applied now.
    task automatic step();
        bit          doPop;
        bit          doPush;
        logic [63:0] entry;
        logic        redir;
        logic [31:0] target;
        redir  = bus.redirect;
        target = bus.redirectPc;
        doPop  = (mq.size() != 0) && bus.idReady && !redir;
        doPush = !redir && ((mq.size() < DEPTH) || doPop);
        entry  = {mPc + 32'd4, romFn(mPc)};
        @(posedge clk);
        if (redir) begin
            mq.delete();
            mPc = {target[31:2], 2'b00};
        end else begin
            if (doPop)  void'(mq.pop_front());
            if (doPush) begin
                mq.push_back(entry);
                mPc = mPc + 32'd4;
            end
        end
        #1;
        $display("txn t=%0t redirect=%0b ready=%0b occ=%0d valid=%0b head_pc4=%h fetch_pc=%h",
                 $time, redir, bus.idReady, bus.occupancy, bus.idValid, bus.idPcPlus4, bus.fetchPc);
    endtask

    task automatic doReset();
        rstN = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rstN = 1'b1;
        mq.delete();
        mPc = RESET_PC;
    endtask

    task automatic test_reset();
        rstN = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (bus.idValid !== 1'b0) begin
            errors++; $display("FAIL reset_valid got=%0b want=0", bus.idValid);
        end
        checks++;
        if (bus.occupancy !== '0) begin
            errors++; $display("FAIL reset_occ got=%0d want=0", bus.occupancy);
        end
        checks++;
        if (bus.fetchPc !== RESET_PC || bus.imemAddr !== RESET_PC) begin
            errors++; $display("FAIL reset_pc got=%h/%h want=%h", bus.fetchPc, bus.imemAddr, RESET_PC);
        end
        checks++;
        if (bus.idPcPlus4 !== 32'd0 || bus.idInstruction !== 32'd0) begin
            errors++; $display("FAIL reset_outputs got=%h/%h want=0/0", bus.idPcPlus4, bus.idInstruction);
        end
        @(negedge clk);
        rstN = 1'b1;
        mq.delete();
        mPc = RESET_PC;
    endtask

    task automatic test_first_fetch();
        bus.idReady = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            checks++;
            if (bus.idValid !== 1'b1 || bus.idPcPlus4 !== RESET_PC + 32'd4 + 32'(4 * k)) begin
                errors++;
                $display("FAIL first_fetch_pc4[%0d] got valid=%0b pc4=%h want valid=1 pc4=%h",
                         k, bus.idValid, bus.idPcPlus4, RESET_PC + 32'd4 + 32'(4 * k));
            end
            checks++;
            if (bus.idInstruction !== romFn(RESET_PC + 32'(4 * k))) begin
                errors++;
                $display("FAIL first_fetch_instr[%0d] got=%h want=%h",
                         k, bus.idInstruction, romFn(RESET_PC + 32'(4 * k)));
            end
        end
    endtask

    task automatic test_stall_and_full();
        doReset();
        bus.idReady = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            step();
            checks++;
            if (int'(bus.occupancy) !== ((i < DEPTH) ? i : DEPTH)) begin
                errors++;
                $display("FAIL stall_occ[%0d] got=%0d want=%0d", i, bus.occupancy, (i < DEPTH) ? i : DEPTH);
            end
        end
        checks++;
        if (bus.fetchPc !== 32'h0040_0010 || bus.imemAddr !== 32'h0040_0010) begin
            errors++; $display("FAIL stall_pc_freeze got=%h want=00400010", bus.fetchPc);
        end
        // Release: heads drain in order while the queue refills each cycle.
        bus.idReady = 1'b1;
        for (int k = 0; k < 6; k++) begin
            checks++;
            if (bus.idPcPlus4 !== 32'h0040_0004 + 32'(4 * k) ||
                bus.idInstruction !== romFn(32'h0040_0000 + 32'(4 * k))) begin
                errors++;
                $display("FAIL drain_order[%0d] got pc4=%h instr=%h want pc4=%h instr=%h", k,
                         bus.idPcPlus4, bus.idInstruction, 32'h0040_0004 + 32'(4 * k),
                         romFn(32'h0040_0000 + 32'(4 * k)));
            end
            step();
            checks++;
            if (int'(bus.occupancy) !== DEPTH || bus.fetchPc !== 32'h0040_0010 + 32'(4 * (k + 1))) begin
                errors++;
                $display("FAIL full_passthru[%0d] got occ=%0d pc=%h want occ=%0d pc=%h", k,
                         bus.occupancy, bus.fetchPc, DEPTH, 32'h0040_0010 + 32'(4 * (k + 1)));
            end
        end
    endtask

    task automatic test_redirect();
        doReset();
        bus.idReady = 1'b0;
        repeat (3) step();
        bus.redirect   = 1'b1;
        bus.redirectPc = 32'h0040_0103;
        step();
        bus.redirect = 1'b0;
        checks++;
        if (bus.occupancy !== '0 || bus.idValid !== 1'b0 || bus.idInstruction !== 32'd0) begin
            errors++;
            $display("FAIL redirect_flush got occ=%0d valid=%0b instr=%h want 0/0/0",
                     bus.occupancy, bus.idValid, bus.idInstruction);
        end
        checks++;
        if (bus.fetchPc !== 32'h0040_0100) begin
            errors++; $display("FAIL redirect_pc got=%h want=00400100", bus.fetchPc);
        end
        bus.idReady = 1'b1;
        step();
        checks++;
        if (bus.idValid !== 1'b1 || bus.idPcPlus4 !== 32'h0040_0104) begin
            errors++; $display("FAIL redirect_target got valid=%0b pc4=%h want 1/00400104",
                               bus.idValid, bus.idPcPlus4);
        end
    endtask

    task automatic test_redirect_full();
        logic [31:0] target;
        doReset();
        bus.idReady = 1'b0;
        repeat (DEPTH + 1) step();
        target = {$urandom(), 2'b00} & 32'h00FF_FFFC;
        bus.idReady    = 1'b1;
        bus.redirect   = 1'b1;
        bus.redirectPc = target;
        step();
        bus.redirect = 1'b0;
        checks++;
        if (bus.occupancy !== '0 || bus.idValid !== 1'b0) begin
            errors++; $display("FAIL redirect_full_flush got occ=%0d valid=%0b want 0/0",
                               bus.occupancy, bus.idValid);
        end
        step();
        checks++;
        if (bus.occupancy !== 3'(1) || bus.idPcPlus4 !== target + 32'd4 ||
            bus.idInstruction !== romFn(target)) begin
            errors++;
            $display("FAIL redirect_full_stale got occ=%0d pc4=%h instr=%h want 1/%h/%h",
                     bus.occupancy, bus.idPcPlus4, bus.idInstruction, target + 32'd4, romFn(target));
        end
    endtask

    task automatic test_back_to_back();
        bus.idReady    = 1'b1;
        bus.redirect   = 1'b1;
        bus.redirectPc = 32'h1000_0020;
        step();
        bus.redirectPc = 32'h2000_0042;
        step();
        bus.redirect = 1'b0;
        checks++;
        if (bus.fetchPc !== 32'h2000_0040 || bus.occupancy !== '0) begin
            errors++; $display("FAIL b2b_pc got pc=%h occ=%0d want 20000040/0", bus.fetchPc, bus.occupancy);
        end
        step();
        checks++;
        if (bus.idPcPlus4 !== 32'h2000_0044) begin
            errors++; $display("FAIL b2b_target got=%h want=20000044", bus.idPcPlus4);
        end
    endtask

    task automatic test_pc_wrap();
        bus.idReady    = 1'b1;
        bus.redirect   = 1'b1;
        bus.redirectPc = 32'hFFFF_FFFF;
        step();
        bus.redirect = 1'b0;
        checks++;
        if (bus.fetchPc !== 32'hFFFF_FFFC) begin
            errors++; $display("FAIL wrap_align got=%h want=fffffffc", bus.fetchPc);
        end
        step();
        checks++;
        if (bus.idValid !== 1'b1 || bus.idPcPlus4 !== 32'd0 || bus.fetchPc !== 32'd0 ||
            bus.idInstruction !== romFn(32'hFFFF_FFFC)) begin
            errors++;
            $display("FAIL wrap_pc got valid=%0b pc4=%h pc=%h instr=%h want 1/00000000/00000000/%h",
                     bus.idValid, bus.idPcPlus4, bus.fetchPc, bus.idInstruction, romFn(32'hFFFF_FFFC));
        end
    endtask

    task automatic test_async_reset();
        doReset();
        bus.idReady = 1'b0;
        repeat (2) step();
        #2;
        rstN = 1'b0;
        #1;
        checks++;
        if (bus.idValid !== 1'b0 || bus.occupancy !== '0 || bus.fetchPc !== RESET_PC ||
            bus.idPcPlus4 !== 32'd0 || bus.idInstruction !== 32'd0) begin
            errors++;
            $display("FAIL async_reset got valid=%0b occ=%0d pc=%h pc4=%h instr=%h want 0/0/%h/0/0",
                     bus.idValid, bus.occupancy, bus.fetchPc, bus.idPcPlus4, bus.idInstruction, RESET_PC);
        end
        @(negedge clk);
        rstN = 1'b1;
        mq.delete();
        mPc = RESET_PC;
        bus.idReady = 1'b1;
        step();
        checks++;
        if (bus.idPcPlus4 !== RESET_PC + 32'd4) begin
            errors++; $display("FAIL async_restart got=%h want=%h", bus.idPcPlus4, RESET_PC + 32'd4);
        end
    endtask

    task automatic test_random();
        doReset();
        for (int n = 0; n < 300; n++) begin
            bus.idReady    = ($urandom_range(0, 3) != 0);
            bus.redirect   = ($urandom_range(0, 11) == 0);
            bus.redirectPc = $urandom();
            step();
            checks++;
            if (bus.idValid !== (mq.size() != 0) || bus.idPcPlus4 !== expPc4() ||
                bus.idInstruction !== expInstr()) begin
                errors++;
                $display("FAIL rand_head[%0d] got valid=%0b pc4=%h instr=%h want valid=%0b pc4=%h instr=%h",
                         n, bus.idValid, bus.idPcPlus4, bus.idInstruction,
                         (mq.size() != 0), expPc4(), expInstr());
            end
            checks++;
            if (int'(bus.occupancy) !== mq.size() || bus.fetchPc !== mPc || bus.imemAddr !== mPc) begin
                errors++;
                $display("FAIL rand_state[%0d] got occ=%0d pc=%h addr=%h want occ=%0d pc=%h",
                         n, bus.occupancy, bus.fetchPc, bus.imemAddr, mq.size(), mPc);
            end
        end
        bus.redirect = 1'b0;
    endtask

    initial begin
        rstN           = 1'b1;
        bus.redirect   = 1'b0;
        bus.redirectPc = 32'd0;
        bus.idReady    = 1'b0;
        mPc            = RESET_PC;
        #1;
        test_reset();
        test_first_fetch();
        test_stall_and_full();
        test_redirect();
        test_redirect_full();
        test_back_to_back();
        test_pc_wrap();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not complete within time limit");
        $fatal(1, "watchdog");
    end

endmodule
